// File: rtl/xadc_aux_pkg.sv
// Shared types and constants for the XADC auxiliary-channel sampler.
package xadc_aux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_REQ,
    ST_WAIT_RDY,
    ST_STORE,
    ST_NEXT
  } aux_state_t;

  localparam int NUM_SLOTS    = 4;
  localparam int IDX_WIDTH    = 2;
  localparam int SAMPLE_WIDTH = 12;
  localparam int MUX_WIDTH    = 4;

  localparam logic [6:0] AUX0_ADDR_DEFAULT = 7'h10;
  localparam logic [6:0] AUX1_ADDR_DEFAULT = 7'h11;
  localparam logic [6:0] AUX2_ADDR_DEFAULT = 7'h12;
  localparam logic [6:0] AUX3_ADDR_DEFAULT = 7'h13;

  localparam logic [MUX_WIDTH-1:0]           MUX_ONE_HOT_BASE = 4'b0001;
  localparam logic [MUX_WIDTH-IDX_WIDTH-1:0] MUX_BIN_PAD      = 2'b00;

  // External mux select for a slot: one-hot (1 << idx) or zero-padded binary.
  function automatic logic [MUX_WIDTH-1:0] mux_encode(input logic [IDX_WIDTH-1:0] idx,
                                                      input logic one_hot);
    return one_hot ? (MUX_ONE_HOT_BASE << idx) : {MUX_BIN_PAD, idx};
  endfunction

endpackage

// File: rtl/xadc_aux_sampler_tick.sv
// Sweep period timer: free-runs while enabled, tick marks each wrap.
module xadc_sample_tick #(
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic S_AXI_ACLK,
  input  logic Local_Reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] period_cnt;

  // Count 0..SAMPLE_PERIOD-1, held at zero while disabled.
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      period_cnt <= '0;
    end else if (!enable || period_cnt == LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  assign tick = enable && (period_cnt == LAST);

endmodule

// File: rtl/xadc_aux_sampler.sv
// Periodic sweep of four XADC aux channels over DRP, with analog mux control.
module xadc_aux_sampler
  import xadc_aux_pkg::*;
#(
  parameter int         SAMPLE_PERIOD = 100000,
  parameter int         SETTLE_CYCLES = 32,
  parameter int         DRP_TIMEOUT   = 255,
  parameter logic [6:0] AUX0_ADDR     = AUX0_ADDR_DEFAULT,
  parameter logic [6:0] AUX1_ADDR     = AUX1_ADDR_DEFAULT,
  parameter logic [6:0] AUX2_ADDR     = AUX2_ADDR_DEFAULT,
  parameter logic [6:0] AUX3_ADDR     = AUX3_ADDR_DEFAULT
) (
  input  logic        S_AXI_ACLK,
  input  logic        Local_Reset,
  input  logic        enable,
  input  logic        one_hot_mux,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [3:0]  mux_sel,
  output logic [11:0] MEASURED_AUX0,
  output logic [11:0] MEASURED_AUX1,
  output logic [11:0] MEASURED_AUX2,
  output logic [11:0] MEASURED_AUX3,
  output logic        sample_done,
  output logic        drp_timeout_err,
  output logic        overrun_err
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int TCW = $clog2(DRP_TIMEOUT + 1);
  localparam logic [SCW-1:0]       SETTLE_LAST  = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0]       TIMEOUT_LAST = TCW'(DRP_TIMEOUT - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_SLOT    = IDX_WIDTH'(NUM_SLOTS - 1);

  aux_state_t              state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [SCW-1:0]          settle_cnt_q;
  logic [TCW-1:0]          tmo_cnt_q;
  logic [SAMPLE_WIDTH-1:0] capture_q;
  logic [SAMPLE_WIDTH-1:0] measured_q [NUM_SLOTS];
  logic [6:0]              daddr_q, slot_addr;
  logic [MUX_WIDTH-1:0]    mux_sel_q;
  logic                    abort_q, abort_now, tick, slot_timeout;
  logic                    timeout_err_q, overrun_err_q;
  logic [3:0]              unused_drp_lsbs;

  xadc_sample_tick #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) u_tick (
    .S_AXI_ACLK  (S_AXI_ACLK),
    .Local_Reset (Local_Reset),
    .enable      (enable),
    .tick        (tick)
  );

  // An enable drop seen during a transaction is remembered so the slot
  // finishes (store or timeout) and the sweep then ends without sample_done.
  assign abort_now    = abort_q || !enable;
  assign slot_timeout = (state_q == ST_WAIT_RDY) && !drp_drdy && (tmo_cnt_q == TIMEOUT_LAST);

  // DRP address of the current slot.
  always_comb begin
    slot_addr = AUX0_ADDR;
    case (idx_q)
      2'd0: slot_addr = AUX0_ADDR;
      2'd1: slot_addr = AUX1_ADDR;
      2'd2: slot_addr = AUX2_ADDR;
      2'd3: slot_addr = AUX3_ADDR;
      default: slot_addr = AUX0_ADDR;
    endcase
  end

  // Next-state logic plus the single-cycle DRP enable and sweep-done pulses.
  always_comb begin
    state_d     = state_q;
    drp_den     = 1'b0;
    sample_done = 1'b0;
    case (state_q)
      ST_IDLE:   if (tick && enable) state_d = ST_SELECT;
      ST_SELECT: state_d = enable ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: begin
        if (!enable)                          state_d = ST_IDLE;
        else if (settle_cnt_q == SETTLE_LAST) state_d = ST_REQ;
      end
      ST_REQ: begin
        drp_den = 1'b1;
        state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (drp_drdy)          state_d = ST_STORE;
        else if (slot_timeout) state_d = abort_now ? ST_IDLE : ST_NEXT;
      end
      ST_STORE:  state_d = abort_now ? ST_IDLE : ST_NEXT;
      ST_NEXT: begin
        if (idx_q == LAST_SLOT) begin
          sample_done = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = enable ? ST_SELECT : ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register, counters, captured data and sticky error flags.
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      settle_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      capture_q     <= '0;
      daddr_q       <= '0;
      mux_sel_q     <= '0;
      abort_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) measured_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (tick && state_q != ST_IDLE) overrun_err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          idx_q   <= '0;
          abort_q <= 1'b0;
        end
        ST_SELECT: begin
          mux_sel_q    <= mux_encode(idx_q, one_hot_mux);
          settle_cnt_q <= '0;
        end
        ST_SETTLE: begin
          settle_cnt_q <= settle_cnt_q + 1'b1;
          if (state_d == ST_REQ) daddr_q <= slot_addr;
        end
        ST_REQ: begin
          tmo_cnt_q <= '0;
          abort_q   <= abort_now;
        end
        ST_WAIT_RDY: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          abort_q   <= abort_now;
          if (drp_drdy)          capture_q     <= drp_do[15:4];
          else if (slot_timeout) timeout_err_q <= 1'b1;
        end
        ST_STORE:  measured_q[idx_q] <= capture_q;
        ST_NEXT:   if (idx_q != LAST_SLOT) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign unused_drp_lsbs = drp_do[3:0];

  assign drp_daddr       = daddr_q;
  assign drp_dwe         = 1'b0;
  assign drp_di          = '0;
  assign mux_sel         = mux_sel_q;
  assign MEASURED_AUX0   = measured_q[0];
  assign MEASURED_AUX1   = measured_q[1];
  assign MEASURED_AUX2   = measured_q[2];
  assign MEASURED_AUX3   = measured_q[3];
  assign drp_timeout_err = timeout_err_q;
  assign overrun_err     = overrun_err_q;

endmodule

// File: tb/tb_xadc_aux_sampler.sv
// Scoreboard bench for xadc_aux_sampler with a behavioural DRP responder.
module tb_xadc_aux_sampler;

  localparam int P = 200;
  localparam int S = 4;
  localparam int T = 60;

  logic        S_AXI_ACLK  = 1'b0;
  logic        Local_Reset = 1'b1;
  logic        enable      = 1'b0;
  logic        one_hot_mux = 1'b0;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do      = '0;
  logic        drp_drdy    = 1'b0;
  logic [3:0]  mux_sel;
  logic [11:0] aux0, aux1, aux2, aux3;
  logic        sample_done, drp_timeout_err, overrun_err;

  xadc_aux_sampler #(
    .SAMPLE_PERIOD (P),
    .SETTLE_CYCLES (S),
    .DRP_TIMEOUT   (T)
  ) dut (
    .S_AXI_ACLK      (S_AXI_ACLK),
    .Local_Reset     (Local_Reset),
    .enable          (enable),
    .one_hot_mux     (one_hot_mux),
    .drp_daddr       (drp_daddr),
    .drp_den         (drp_den),
    .drp_dwe         (drp_dwe),
    .drp_di          (drp_di),
    .drp_do          (drp_do),
    .drp_drdy        (drp_drdy),
    .mux_sel         (mux_sel),
    .MEASURED_AUX0   (aux0),
    .MEASURED_AUX1   (aux1),
    .MEASURED_AUX2   (aux2),
    .MEASURED_AUX3   (aux3),
    .sample_done     (sample_done),
    .drp_timeout_err (drp_timeout_err),
    .overrun_err     (overrun_err)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  int unsigned cyc = 0;
  always @(posedge S_AXI_ACLK) cyc <= cyc + 1;

  int unsigned vectors = 0, miscompares = 0;
  int unsigned done_seen = 0, done_cyc = 0;

  typedef struct packed { logic [6:0] addr; logic [3:0] mux; } den_exp_t;
  typedef struct packed { logic [11:0] a0, a1, a2, a3; logic tmo; } done_exp_t;
  den_exp_t  den_q[$];
  done_exp_t done_q[$];

  // Environment: per-slot DRP response data, latency and whether it answers.
  logic [15:0] rsp_data [4];
  int          rsp_lat  [4];
  bit          rsp_on   [4];

  // Reference state: what each slot should hold, and the sticky timeout flag.
  logic [11:0] model_aux [4];
  logic        model_tmo = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    vectors++;
    if (act < exp - tol || act > exp + tol) begin
      miscompares++;
      $display("FAIL %s: got %0d cycles, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic logic [11:0] dut_aux(input int i);
    case (i)
      0: return aux0;
      1: return aux1;
      2: return aux2;
      default: return aux3;
    endcase
  endfunction

  // Tick-to-done time from the cycle enable rises: one period, then per slot
  // select + settle + request + response wait + store + next (a timeout has no store).
  function automatic int expected_edges();
    int e = P - 1;
    for (int i = 0; i < 4; i++) e += rsp_on[i] ? (S + 4 + rsp_lat[i]) : (S + 3 + T);
    return e;
  endfunction

  // Queue the expected DRP requests for the first n slots and update the model.
  task automatic plan_slots(input int n, input bit oh, input bit with_done);
    den_exp_t d;
    done_exp_t e;
    for (int i = 0; i < n; i++) begin
      d.addr = 7'h10 + 7'(i);
      d.mux  = oh ? (4'b0001 << i) : 4'(i);
      den_q.push_back(d);
      if (rsp_on[i]) model_aux[i] = rsp_data[i][15:4];
      else           model_tmo    = 1'b1;
    end
    if (with_done) begin
      e.a0 = model_aux[0]; e.a1 = model_aux[1];
      e.a2 = model_aux[2]; e.a3 = model_aux[3];
      e.tmo = model_tmo;
      done_q.push_back(e);
    end
  endtask

  task automatic randomize_rsp(input int max_lat);
    for (int i = 0; i < 4; i++) begin
      rsp_data[i] = 16'($urandom);
      rsp_lat[i]  = $urandom_range(1, max_lat);
      rsp_on[i]   = 1'b1;
    end
  endtask

  task automatic wait_done(output bit ok);
    int unsigned n0 = done_seen;
    ok = 1'b0;
    for (int g = 0; g < 4000; g++) begin
      @(negedge S_AXI_ACLK); #1;
      if (done_seen != n0) begin ok = 1'b1; break; end
    end
    check("sample_done_arrived", 32'(ok), 32'd1);
  endtask

  task automatic wait_den(input logic [6:0] addr, output bit ok);
    ok = 1'b0;
    for (int g = 0; g < 2000; g++) begin
      @(negedge S_AXI_ACLK); #1;
      if (drp_den === 1'b1 && drp_daddr == addr) begin ok = 1'b1; break; end
    end
    check("den_arrived", 32'(ok), 32'd1);
  endtask

  task automatic run_sweep(input bit oh);
    int exp_edges;
    int unsigned t0;
    bit ok;
    one_hot_mux = oh;
    exp_edges = expected_edges();
    plan_slots(4, oh, 1'b1);
    @(posedge S_AXI_ACLK); #1;
    t0 = cyc;
    enable = 1'b1;
    wait_done(ok);
    enable = 1'b0;
    if (ok) check_near("sweep_latency", int'(done_cyc - t0), exp_edges, 1);
    repeat (5) @(posedge S_AXI_ACLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mux_sel"}, 32'(mux_sel), 32'h0);
    for (int i = 0; i < 4; i++) check({tag, "_aux"}, 32'(dut_aux(i)), 32'h0);
    check({tag, "_timeout_err"}, 32'(drp_timeout_err), 32'h0);
    check({tag, "_overrun_err"}, 32'(overrun_err), 32'h0);
    check({tag, "_sample_done"}, 32'(sample_done), 32'h0);
    check({tag, "_den"}, 32'(drp_den), 32'h0);
    check({tag, "_daddr"}, 32'(drp_daddr), 32'h0);
    check({tag, "_dwe_di"}, {15'b0, drp_dwe, drp_di}, 32'h0);
  endtask

  // DRP responder: answers each request after its slot's latency.
  initial begin : drp_responder
    int s;
    forever begin
      @(negedge S_AXI_ACLK);
      if (drp_den === 1'b1 && drp_daddr >= 7'h10 && drp_daddr <= 7'h13) begin
        s = int'(drp_daddr) - 16;
        if (rsp_on[s]) begin
          repeat (rsp_lat[s]) @(posedge S_AXI_ACLK);
          #1;
          drp_do   = rsp_data[s];
          drp_drdy = 1'b1;
          @(posedge S_AXI_ACLK); #1;
          drp_drdy = 1'b0;
        end
      end
    end
  end

  // Request monitor: address, mux select, settle time and single-cycle den.
  initial begin : den_monitor
    logic [3:0]  prev_mux = '0;
    logic        prev_den = 1'b0;
    int unsigned hold = 0;
    den_exp_t    e;
    forever begin
      @(negedge S_AXI_ACLK);
      if (drp_den === 1'b1) begin
        if (prev_den) check("den_single_cycle", 32'(drp_den), 32'h0);
        else if (den_q.size() == 0) check("spurious_den", 32'(drp_den), 32'h0);
        else begin
          e = den_q.pop_front();
          check("den_addr", 32'(drp_daddr), 32'(e.addr));
          check("den_mux_sel", 32'(mux_sel), 32'(e.mux));
          vectors++;
          if (hold < S) begin
            miscompares++;
            $display("FAIL mux_settle: held %0d cycles, required >= %0d", hold, S);
          end
        end
      end
      prev_den = drp_den;
      if (mux_sel !== prev_mux) hold = 1;
      else hold++;
      prev_mux = mux_sel;
    end
  end

  // Completion monitor: sweep results and timeout flag at each sample_done.
  initial begin : done_monitor
    done_exp_t e;
    forever begin
      @(negedge S_AXI_ACLK);
      if (sample_done === 1'b1) begin
        done_seen++;
        done_cyc = cyc;
        if (done_q.size() == 0) check("spurious_done", 32'(sample_done), 32'h0);
        else begin
          e = done_q.pop_front();
          check("done_aux0", 32'(aux0), 32'(e.a0));
          check("done_aux1", 32'(aux1), 32'(e.a1));
          check("done_aux2", 32'(aux2), 32'(e.a2));
          check("done_aux3", 32'(aux3), 32'(e.a3));
          check("done_timeout_err", 32'(drp_timeout_err), 32'(e.tmo));
        end
      end
    end
  end

  initial begin : stimulus
    bit ok;
    int unsigned t0, n0;
    for (int i = 0; i < 4; i++) begin
      model_aux[i] = '0; rsp_data[i] = '0; rsp_lat[i] = 3; rsp_on[i] = 1'b1;
    end

    repeat (3) @(posedge S_AXI_ACLK);
    @(negedge S_AXI_ACLK);
    check_all_zero("reset");
    Local_Reset = 1'b0;
    repeat (3) @(posedge S_AXI_ACLK);

    // Directed sweep with known codes, binary mux.
    rsp_data[0] = 16'hABC0; rsp_data[1] = 16'h1230;
    rsp_data[2] = 16'h0FF0; rsp_data[3] = 16'hFFF0;
    run_sweep(1'b0);
    check("directed_aux0", 32'(aux0), 32'hABC);
    check("directed_aux3", 32'(aux3), 32'hFFF);

    // Randomized sweeps in both mux encodings.
    for (int n = 0; n < 6; n++) begin
      randomize_rsp(30);
      run_sweep(n[0]);
    end
    check("overrun_err_clear", 32'(overrun_err), 32'h0);
    check("timeout_err_clear", 32'(drp_timeout_err), 32'h0);

    // Slot 2 never answers: flag sets, slot 2 keeps its old value.
    randomize_rsp(30);
    rsp_on[2] = 1'b0;
    run_sweep($urandom_range(0, 1) == 1);
    check("timeout_err_set", 32'(drp_timeout_err), 32'h1);
    check("overrun_err_after_timeout", 32'(overrun_err), 32'h0);

    // Slow DRP stretches the sweep past one period: tick dropped, sweep completes.
    randomize_rsp(1);
    for (int i = 0; i < 4; i++) rsp_lat[i] = 50;
    run_sweep(1'b1);
    check("overrun_err_set", 32'(overrun_err), 32'h1);

    // Enable drops while slot 1 waits: slot 1 stored, no further requests.
    randomize_rsp(5);
    rsp_lat[1] = 15;
    one_hot_mux = 1'b0;
    plan_slots(2, 1'b0, 1'b0);
    n0 = done_seen;
    @(posedge S_AXI_ACLK); #1;
    enable = 1'b1;
    wait_den(7'h11, ok);
    @(posedge S_AXI_ACLK); #1;
    enable = 1'b0;
    repeat (300) @(negedge S_AXI_ACLK);
    for (int i = 0; i < 4; i++) check("abort_aux", 32'(dut_aux(i)), 32'(model_aux[i]));
    check("abort_den_left", den_q.size(), 32'd0);
    check("abort_no_done", done_seen - n0, 32'd0);

    // Reset while a read is outstanding; the late drdy must be ignored.
    randomize_rsp(5);
    rsp_lat[0] = 20;
    one_hot_mux = 1'b1;
    plan_slots(1, 1'b1, 1'b0);
    @(posedge S_AXI_ACLK); #1;
    enable = 1'b1;
    wait_den(7'h10, ok);
    repeat (5) @(posedge S_AXI_ACLK);
    #2 Local_Reset = 1'b1;
    #1 check_all_zero("midreset");
    den_q.delete();
    done_q.delete();
    for (int i = 0; i < 4; i++) model_aux[i] = '0;
    model_tmo = 1'b0;
    randomize_rsp(5);
    plan_slots(4, 1'b1, 1'b1);
    repeat (3) @(posedge S_AXI_ACLK);
    @(negedge S_AXI_ACLK);
    Local_Reset = 1'b0;
    t0 = cyc;
    repeat (30) @(negedge S_AXI_ACLK);
    #1 check("late_drdy_ignored_aux0", 32'(aux0), 32'h0);
    wait_den(7'h10, ok);
    if (ok) check_near("first_den_after_reset", int'(cyc - t0), P + S + 1, 1);
    wait_done(ok);
    enable = 1'b0;
    repeat (10) @(posedge S_AXI_ACLK);
    check("final_den_q_empty", den_q.size(), 32'd0);
    check("final_done_q_empty", done_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
